// File: rtl/sap_loader.sv
// sap_loader: byte-stream program loader for the SAPone 16x8 program RAM.
// It takes program bytes over a valid/ready handshake and writes them to
// consecutive RAM addresses. The CPU is held in clear while a load is in
// progress and is released a fixed delay after the last write.
// Optional feature macro: SAP_LOADER_CHECKSUM_EN. When it is defined, the
// host sends one more byte after the program: the mod-256 sum of the
// program bytes. If that byte does not match, the CPU stays held and err
// is raised.
// Every output comes straight from a register. The next-state logic works
// out each output's next value from the state the FSM is about to enter.
module sap_loader #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int RELEASE_DLY = 2
) (
    input  logic              clk,
    input  logic              clr_,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_data,
    output logic              prog_we,
    output logic              cpu_clr_,
    output logic              done,
    output logic              err
);

    // Width of the release-delay counter. It must be able to hold
    // RELEASE_DLY-1.
    localparam int DLY_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(RELEASE_DLY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_CHECK = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // The address counter holds the RAM address that the next accepted
    // byte will go to.
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [DLY_W-1:0]  r_dly;
    logic [DLY_W-1:0]  w_dly_next;

    // Registered output values.
    logic              r_in_ready;
    logic              w_in_ready_next;
    logic [ADDR_W-1:0] r_prog_addr;
    logic [ADDR_W-1:0] w_prog_addr_next;
    logic [7:0]        r_prog_data;
    logic [7:0]        w_prog_data_next;
    logic              r_prog_we;
    logic              w_prog_we_next;
    logic              r_run;
    logic              w_run_next;

    // A byte transfers only while in_ready is already high. in_ready is
    // registered and is high exactly in the states that take bytes.
    logic              w_accept;
    assign w_accept = in_valid & r_in_ready;

`ifdef SAP_LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic [7:0]        w_sum_next;
    logic              r_err;
    logic              w_err_next;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_dly       <= '0;
            r_in_ready  <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_we   <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_dly       <= w_dly_next;
            r_in_ready  <= w_in_ready_next;
            r_prog_addr <= w_prog_addr_next;
            r_prog_data <= w_prog_data_next;
            r_prog_we   <= w_prog_we_next;
            r_run       <= w_run_next;
        end
    end

`ifdef SAP_LOADER_CHECKSUM_EN
    // Checksum accumulator and the sticky error flag.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            r_sum <= w_sum_next;
            r_err <= w_err_next;
        end
    end
`endif

    // Next-state logic, counter updates and next output values.
    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_dly_next       = r_dly;
        w_prog_addr_next = r_prog_addr;
        w_prog_data_next = r_prog_data;
`ifdef SAP_LOADER_CHECKSUM_EN
        w_sum_next       = r_sum;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_addr_next  = '0;
`ifdef SAP_LOADER_CHECKSUM_EN
                    w_sum_next   = '0;
`endif
                end
            end

            S_LOAD: begin
                if (w_accept) begin
                    w_state_next     = S_WRITE;
                    w_prog_addr_next = r_addr;
                    w_prog_data_next = in_data;
`ifdef SAP_LOADER_CHECKSUM_EN
                    w_sum_next       = r_sum + in_data;
`endif
                end
            end

            // The write strobe is high in this state. On the last address
            // the counter stops at LAST_ADDR instead of wrapping to 0.
            S_WRITE: begin
                if (r_addr == LAST_ADDR) begin
`ifdef SAP_LOADER_CHECKSUM_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_HOLD;
`endif
                    w_dly_next   = '0;
                end else begin
                    w_state_next = S_LOAD;
                    w_addr_next  = r_addr + 1'b1;
                end
            end

            S_HOLD: begin
                if (r_dly == DLY_LAST) begin
                    w_state_next = S_RUN;
                end else begin
                    w_dly_next = r_dly + 1'b1;
                end
            end

            S_RUN: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_addr_next  = '0;
`ifdef SAP_LOADER_CHECKSUM_EN
                    w_sum_next   = '0;
`endif
                end
            end

`ifdef SAP_LOADER_CHECKSUM_EN
            // The trailing byte must equal the running sum of the program.
            S_CHECK: begin
                if (w_accept) begin
                    if (in_data == r_sum) begin
                        w_state_next = S_HOLD;
                        w_dly_next   = '0;
                    end else begin
                        w_state_next = S_ERROR;
                    end
                end
            end

            S_ERROR: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_addr_next  = '0;
                    w_sum_next   = '0;
                end
            end
`endif

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Outputs are decoded from the state being entered, so that every
        // output lines up with its state while still coming from a register.
        w_in_ready_next = (w_state_next == S_LOAD) || (w_state_next == S_CHECK);
        w_prog_we_next  = (w_state_next == S_WRITE);
        w_run_next      = (w_state_next == S_RUN);
`ifdef SAP_LOADER_CHECKSUM_EN
        w_err_next      = (w_state_next == S_ERROR);
`endif
    end

    assign in_ready  = r_in_ready;
    assign prog_addr = r_prog_addr;
    assign prog_data = r_prog_data;
    assign prog_we   = r_prog_we;
    // cpu_clr_ and done both come from the same register, so they always
    // rise and fall on the same edge.
    assign cpu_clr_  = r_run;
    assign done      = r_run;
`ifdef SAP_LOADER_CHECKSUM_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sap_loader.sv
// Testbench for sap_loader. It drives random program bytes with varying
// gaps between them. It checks every RAM write, the release timing and the
// handshake against expectations that it computes itself.
// To exercise the checksum option, build with SAP_LOADER_CHECKSUM_EN defined.
module tb_sap_loader;
    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int RELEASE_DLY = 2;
`ifdef SAP_LOADER_CHECKSUM_EN
    localparam int NBYTES = DEPTH + 1;
    localparam bit CSUM   = 1'b1;
`else
    localparam int NBYTES = DEPTH;
    localparam bit CSUM   = 1'b0;
`endif

    logic              clk;
    logic              clr_;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              prog_we;
    logic              cpu_clr_;
    logic              done;
    logic              err;

    sap_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RELEASE_DLY(RELEASE_DLY)) dut (
        .clk(clk), .clr_(clr_), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
        .cpu_clr_(cpu_clr_), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Cycle counter, used to timestamp accepts and writes.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM write monitor. It also watches that cpu_clr_ and done move together.
    typedef struct { int addr; int data; int c; } wr_t;
    wr_t  obs[$];
    int   rise_cyc  = -1;
    int   sync_viol = 0;
    logic prev_clr  = 1'b0;
    always @(negedge clk) begin
        if (prog_we === 1'b1) obs.push_back('{int'(prog_addr), int'(prog_data), cyc});
        if (done !== cpu_clr_) sync_viol++;
        if (cpu_clr_ === 1'b1 && prev_clr !== 1'b1) rise_cyc = cyc;
        prev_clr = cpu_clr_;
    end

    // Reference data for one load, and the cycle in which each byte was accepted.
    logic [7:0] stim [NBYTES];
    int         acc_cyc [NBYTES];
    int         ready_viol;

    // Fill the stimulus: mode 0 = data equals address, 1 = random, 2 = all 0x01.
    // If bad_sum is set, the trailing checksum byte is deliberately off by one.
    task automatic make_stim(input int mode, input bit bad_sum);
        int sum;
        sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            case (mode)
                0:       stim[i] = 8'(i);
                1:       stim[i] = 8'($urandom);
                default: stim[i] = 8'h01;
            endcase
            sum = (sum + int'(stim[i])) % 256;
        end
        if (CSUM) stim[NBYTES-1] = 8'((sum + (bad_sum ? 1 : 0)) % 256);
    endtask

    // Offer the first n stimulus bytes. gap is the number of cycles that
    // in_valid stays low after each accept. If noise is set, start is
    // toggled at random during the load. The task returns in the first
    // cycle after the final accept.
    task automatic drive_load(input int n, input int gap, input bit noise);
        int idx, idle, guard;
        idx = 0; idle = 0; guard = 0;
        while (idx < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (noise) start = 1'($urandom_range(0, 1));
            if (idle > 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                idle--;
            end else begin
                in_valid = 1'b1;
                in_data  = stim[idx];
                if (in_ready === 1'b1) begin
                    acc_cyc[idx] = cyc + 1;
                    idx++;
                    idle = gap;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        vectors++;
        if (idx !== n) begin
            miscompares++;
            $display("FAIL accept_timeout: accepted %0d bytes, required %0d", idx, n);
        end
    endtask

    // Wait, with a cycle bound, for the CPU to be released. If hold_valid
    // is set, in_valid is held high throughout the wait. Any cycle with
    // in_ready high is counted as a violation.
    task automatic wait_run(input bit hold_valid);
        int guard;
        guard = 0;
        ready_viol = 0;
        while (cpu_clr_ !== 1'b1 && guard < 100) begin
            if (hold_valid) begin in_valid = 1'b1; in_data = 8'($urandom); end
            @(negedge clk);
            #1;
            if (cpu_clr_ !== 1'b1 && in_ready !== 1'b0) ready_viol++;
            guard++;
        end
        in_valid = 1'b0;
        vectors++;
        if (cpu_clr_ !== 1'b1) begin
            miscompares++;
            $display("FAIL run_timeout: cpu_clr_=%b after %0d cycles, required 1", cpu_clr_, guard);
        end
    endtask

    task automatic test_reset();
        clr_ = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #2 clr_ = 1'b0;
        #1;
        vectors += 7;
        if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (prog_addr !== '0)   begin miscompares++; $display("FAIL reset_prog_addr: got %0h want 0", prog_addr); end
        if (prog_data !== 8'h0) begin miscompares++; $display("FAIL reset_prog_data: got %0h want 0", prog_data); end
        if (prog_we !== 1'b0)   begin miscompares++; $display("FAIL reset_prog_we: got %b want 0", prog_we); end
        if (cpu_clr_ !== 1'b0)  begin miscompares++; $display("FAIL reset_cpu_clr_: got %b want 0", cpu_clr_); end
        if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== 1'b0)       begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        repeat (3) @(negedge clk);
        clr_ = 1'b1;
        $display("reset: outputs checked at reset values");
    endtask

    // Hold in_valid high in IDLE (want_run=0) or in RUN (want_run=1). Nothing
    // may be accepted or written, and the state must not change.
    task automatic test_ignore_valid(input bit want_run);
        int n0;
        obs.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            vectors += 2;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ignore_ready: got %b want 0", in_ready); end
            if (cpu_clr_ !== want_run) begin miscompares++; $display("FAIL ignore_state: cpu_clr_=%b want %b", cpu_clr_, want_run); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n0 = obs.size();
        vectors++;
        if (n0 !== 0) begin miscompares++; $display("FAIL ignore_we: %0d writes, want 0", n0); end
        $display("ignore_valid(run=%0d): in_valid held 5 cycles, writes=%0d", want_run, n0);
    endtask

    // A complete load, followed by checks on every write and on the release timing.
    task automatic test_load(input int mode, input int gap, input bit noise,
                             input bit hold_valid, input bit from_run);
        int exp_rise;
        make_stim(mode, 1'b0);
        obs.delete();
        rise_cyc  = -1;
        sync_viol = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        #1;
        vectors += 2;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL load_entry_ready: got %b want 1", in_ready); end
        if (cpu_clr_ !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_entry_held: cpu_clr_=%b done=%b want 0 0 (from_run=%0d)", cpu_clr_, done, from_run);
        end
        drive_load(NBYTES, gap, noise);
        wait_run(hold_valid);
        #1;
        vectors++;
        if (obs.size() !== DEPTH) begin miscompares++; $display("FAIL write_count: got %0d want %0d", obs.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
            vectors += 3;
            if (obs[i].addr !== i) begin miscompares++; $display("FAIL write_addr[%0d]: got %0h want %0h", i, obs[i].addr, i); end
            if (obs[i].data !== int'(stim[i])) begin miscompares++; $display("FAIL write_data[%0d]: got %0h want %0h", i, obs[i].data, stim[i]); end
            if (obs[i].c !== acc_cyc[i]) begin miscompares++; $display("FAIL write_cycle[%0d]: got %0d want %0d", i, obs[i].c, acc_cyc[i]); end
        end
        // After the last program write: one cycle to leave WRITE, then
        // RELEASE_DLY cycles of hold. With the checksum option, the hold
        // starts directly from the accept of the checksum byte.
        exp_rise = CSUM ? acc_cyc[NBYTES-1] + RELEASE_DLY : acc_cyc[DEPTH-1] + 1 + RELEASE_DLY;
        vectors += 5;
        if (rise_cyc !== exp_rise) begin miscompares++; $display("FAIL release_cycle: got %0d want %0d", rise_cyc, exp_rise); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL run_done: got %b want 1", done); end
        if (err !== 1'b0) begin miscompares++; $display("FAIL run_err: got %b want 0", err); end
        if (sync_viol !== 0) begin miscompares++; $display("FAIL done_sync: %0d cycles with done!=cpu_clr_, want 0", sync_viol); end
        if (ready_viol !== 0) begin miscompares++; $display("FAIL hold_ready: %0d cycles with in_ready high, want 0", ready_viol); end
        $display("load(mode=%0d gap=%0d noise=%0d hv=%0d run=%0d): %0d writes, release at %0d (want %0d)",
                 mode, gap, noise, hold_valid, from_run, obs.size(), rise_cyc, exp_rise);
    endtask

    // Assert reset asynchronously right after the 7th write.
    task automatic test_reset_mid_load();
        make_stim(1, 1'b0);
        obs.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        drive_load(7, 0, 1'b0);
        #1;
        vectors++;
        if (obs.size() !== 7) begin miscompares++; $display("FAIL midreset_writes: got %0d want 7", obs.size()); end
        #2 clr_ = 1'b0;
        #1;
        vectors += 6;
        if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL midreset_in_ready: got %b want 0", in_ready); end
        if (prog_addr !== '0)   begin miscompares++; $display("FAIL midreset_prog_addr: got %0h want 0", prog_addr); end
        if (prog_data !== 8'h0) begin miscompares++; $display("FAIL midreset_prog_data: got %0h want 0", prog_data); end
        if (prog_we !== 1'b0)   begin miscompares++; $display("FAIL midreset_prog_we: got %b want 0", prog_we); end
        if (cpu_clr_ !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_held: cpu_clr_=%b done=%b want 0 0", cpu_clr_, done); end
        if (err !== 1'b0)       begin miscompares++; $display("FAIL midreset_err: got %b want 0", err); end
        @(negedge clk) clr_ = 1'b1;
        $display("reset_mid_load: 7 writes, then reset, outputs checked");
    endtask

`ifdef SAP_LOADER_CHECKSUM_EN
    // Send a wrong checksum: the loader must enter ERROR, and start must
    // then recover it.
    task automatic test_checksum_error();
        int guard;
        make_stim(2, 1'b1);
        obs.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        drive_load(NBYTES, 0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        vectors += 5;
        if (err !== 1'b1)      begin miscompares++; $display("FAIL csum_err: got %b want 1", err); end
        if (cpu_clr_ !== 1'b0) begin miscompares++; $display("FAIL csum_cpu_clr_: got %b want 0", cpu_clr_); end
        if (done !== 1'b0)     begin miscompares++; $display("FAIL csum_done: got %b want 0", done); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL csum_ready: got %b want 0", in_ready); end
        if (obs.size() !== DEPTH) begin miscompares++; $display("FAIL csum_writes: got %0d want %0d", obs.size(), DEPTH); end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        #1;
        vectors += 2;
        if (err !== 1'b0)      begin miscompares++; $display("FAIL csum_clear_err: got %b want 0", err); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL csum_reload_ready: got %b want 1", in_ready); end
        make_stim(1, 1'b0);
        drive_load(NBYTES, 1, 1'b0);
        guard = 0;
        wait_run(1'b0);
        $display("checksum_error: err raised on a bad sum, cleared by start, reload ran=%b", cpu_clr_);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ignore_valid(1'b0);
        test_load(0, 0, 1'b0, 1'b1, 1'b0);
        test_ignore_valid(1'b1);
        test_load(1, 3, 1'b0, 1'b0, 1'b1);
        test_load(1, 1, 1'b1, 1'b1, 1'b1);
        test_reset_mid_load();
        test_load(1, 0, 1'b1, 1'b0, 1'b0);
`ifdef SAP_LOADER_CHECKSUM_EN
        test_load(2, 0, 1'b0, 1'b0, 1'b1);
        test_checksum_error();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
